// File: rtl/pixel_frame_store.sv
// WIDTH x HEIGHT x 3-bit frame store: processor plot/lookup port, raster-scan read port and an FSM-driven full-frame clear.
// Optional macro PIXEL_FRAME_STORE_CLEAR_ON_RESET_EN: reset enters the clear sweep instead of RUN.
module pixel_frame_store #(
  parameter int unsigned WIDTH     = 160,
  parameter int unsigned HEIGHT    = 120,
  parameter logic [2:0]  BG_COLOR  = 3'b000,
  parameter logic [2:0]  OOB_COLOR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] color_draw,
  input  logic       plot,
  output logic [2:0] color_obs,
  input  logic       clear,
  output logic       busy,
  input  logic       scan_en,
  output logic [7:0] scan_x,
  output logic [7:0] scan_y,
  output logic [2:0] scan_color,
  output logic       scan_valid,
  output logic       frame_start
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = 15;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [7:0]    LAST_X    = 8'(WIDTH - 1);
  localparam logic [7:0]    LAST_Y    = 8'(HEIGHT - 1);

  typedef enum logic {
    ST_RUN,
    ST_CLEAR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   sweep_addr;
  logic [AW-1:0]   sweep_addr_nxt;

  logic [2:0]      mem [DEPTH];

  logic            in_range;
  logic [AW-1:0]   pix_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [2:0]      wr_dat;

  logic [7:0]      sx;
  logic [7:0]      sy;
  logic [AW-1:0]   scan_addr;

  // Unsigned compare in 32 bits so out-of-range coordinates are never wrapped into the frame.
  assign in_range  = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
  assign pix_addr  = AW'(32'(y) * WIDTH + 32'(x));
  assign scan_addr = AW'(32'(sy) * WIDTH + 32'(sx));
  assign busy      = (state == ST_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef PIXEL_FRAME_STORE_CLEAR_ON_RESET_EN
      state <= ST_CLEAR;
`else
      state <= ST_RUN;
`endif
      sweep_addr <= '0;
    end else begin
      state      <= state_nxt;
      sweep_addr <= sweep_addr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sweep_addr_nxt = sweep_addr;
    wr_en          = 1'b0;
    wr_addr        = pix_addr;
    wr_dat         = color_draw;
    case (state)
      ST_RUN: begin
        wr_en = plot && in_range;
        if (clear) begin
          state_nxt      = ST_CLEAR;
          sweep_addr_nxt = '0;
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = sweep_addr;
        wr_dat  = BG_COLOR;
        if (sweep_addr == LAST_ADDR) begin
          state_nxt = ST_RUN;
        end else begin
          sweep_addr_nxt = sweep_addr + AW'(1);
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    // No memory writes while reset is held, so an interrupted sweep leaves the frame as it was.
    if (reset) begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // In RUN a write always targets the lookup address, so forwarding wr_dat gives write-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_obs <= '0;
    end else if (!in_range) begin
      color_obs <= OOB_COLOR;
    end else if (state == ST_CLEAR) begin
      color_obs <= BG_COLOR;
    end else if (wr_en) begin
      color_obs <= wr_dat;
    end else begin
      color_obs <= mem[pix_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx          <= '0;
      sy          <= '0;
      scan_x      <= '0;
      scan_y      <= '0;
      scan_color  <= '0;
      scan_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      scan_valid  <= scan_en;
      frame_start <= scan_en && (sx == '0) && (sy == '0);
      if (scan_en) begin
        scan_x     <= sx;
        scan_y     <= sy;
        scan_color <= (wr_en && (wr_addr == scan_addr)) ? wr_dat : mem[scan_addr];
        if (sx == LAST_X) begin
          sx <= '0;
          sy <= (sy == LAST_Y) ? 8'd0 : sy + 8'd1;
        end else begin
          sx <= sx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_store.sv
// Randomized bench for pixel_frame_store: a frame-level model (linear pixel index, per-pixel known flags) checked every cycle,
// plus literal expectations for readback, out-of-range, clear length, frame period, write-first and reset mid-sweep.
module tb_pixel_frame_store;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic [2:0] color_draw = '0;
  logic       plot = 1'b0;
  logic       clear = 1'b0;
  logic       scan_en = 1'b0;
  logic [2:0] color_obs;
  logic       busy;
  logic [7:0] scan_x;
  logic [7:0] scan_y;
  logic [2:0] scan_color;
  logic       scan_valid;
  logic       frame_start;

  pixel_frame_store dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .color_draw(color_draw), .plot(plot),
    .color_obs(color_obs), .clear(clear), .busy(busy), .scan_en(scan_en),
    .scan_x(scan_x), .scan_y(scan_y), .scan_color(scan_color),
    .scan_valid(scan_valid), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Frame model: memory as a flat array with known flags, scan as a single pixel index.
  logic [2:0] mm [N];
  bit         mk [N];
  bit         m_clearing;
  int         m_cidx;
  int         m_pos;
  int         xi, yi, ai;
  bit         inr, start_clear;
  logic [2:0] e_obs, e_scol;
  bit         e_obs_k, e_scol_k, e_sval, e_fs;
  logic [7:0] e_sx, e_sy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_obs = '0; e_obs_k = 1; e_scol = '0; e_scol_k = 1;
      e_sx = '0; e_sy = '0; e_sval = 0; e_fs = 0; m_pos = 0; m_cidx = 0;
`ifdef PIXEL_FRAME_STORE_CLEAR_ON_RESET_EN
      m_clearing = 1;
`else
      m_clearing = 0;
`endif
    end else begin
      xi = int'(x); yi = int'(y);
      inr = (xi < W) && (yi < H);
      ai = yi * W + xi;
      if (!inr) begin e_obs = 3'b111; e_obs_k = 1; end
      else if (m_clearing) begin e_obs = 3'b000; e_obs_k = 1; end
      else if (plot) begin e_obs = color_draw; e_obs_k = 1; end
      else begin e_obs = mm[ai]; e_obs_k = mk[ai]; end
      start_clear = !m_clearing && clear;
      if (m_clearing) begin
        mm[m_cidx] = 3'b000; mk[m_cidx] = 1;
        m_cidx++;
        if (m_cidx == N) m_clearing = 0;
      end else if (plot && inr) begin
        mm[ai] = color_draw; mk[ai] = 1;
      end
      if (start_clear) begin m_clearing = 1; m_cidx = 0; end
      if (scan_en) begin
        e_sval = 1; e_fs = (m_pos == 0);
        e_sx = 8'(m_pos % W); e_sy = 8'(m_pos / W);
        e_scol = mm[m_pos]; e_scol_k = mk[m_pos];
        m_pos = (m_pos + 1) % N;
      end else begin
        e_sval = 0; e_fs = 0;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 16'(busy), 16'(m_clearing));
      chk("scan_valid", 16'(scan_valid), 16'(e_sval));
      chk("frame_start", 16'(frame_start), 16'(e_fs));
      chk("scan_x", 16'(scan_x), 16'(e_sx));
      chk("scan_y", 16'(scan_y), 16'(e_sy));
      if (e_obs_k) chk("color_obs", 16'(color_obs), 16'(e_obs));
      if (e_scol_k) chk("scan_color", 16'(scan_color), 16'(e_scol));
    end
  end

  // Frame-start timing and the last scan pixel before each wrap.
  int         cyc = 0;
  int         fs_q[$];
  bit         had_prev = 0;
  logic [7:0] lx, ly;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      had_prev = 0;
    end else if (scan_valid) begin
      if (frame_start) begin
        fs_q.push_back(cyc);
        if (had_prev) begin
          chk("wrap_prev_x", 16'(lx), 16'd159);
          chk("wrap_prev_y", 16'(ly), 16'd119);
        end
      end
      lx = scan_x; ly = scan_y; had_prev = 1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic plot_px(input int px, input int py, input logic [2:0] c);
    x = 8'(px); y = 8'(py); color_draw = c; plot = 1; step(); plot = 0;
  endtask

  task automatic lookup(input int px, input int py);
    x = 8'(px); y = 8'(py); plot = 0; step();
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin step(); n++; end
    if (busy) chk("idle_timeout", 16'(busy), 16'd0);
  endtask

  task automatic random_traffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      x = 8'($urandom_range(0, 170)); y = 8'($urandom_range(0, 130));
      plot = 1'($urandom_range(0, 1)); color_draw = 3'($urandom_range(0, 7));
      scan_en = ($urandom_range(0, 3) != 0);
      step();
    end
    plot = 0; scan_en = 1;
  endtask

  int bc;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    repeat (3) step();
    chk("rst_color_obs", 16'(color_obs), 16'd0);
    chk("rst_scan_x", 16'(scan_x), 16'd0);
    chk("rst_scan_y", 16'(scan_y), 16'd0);
    chk("rst_scan_color", 16'(scan_color), 16'd0);
    chk("rst_scan_valid", 16'(scan_valid), 16'd0);
    chk("rst_frame_start", 16'(frame_start), 16'd0);
`ifdef PIXEL_FRAME_STORE_CLEAR_ON_RESET_EN
    chk("rst_busy", 16'(busy), 16'd1);
`else
    chk("rst_busy", 16'(busy), 16'd0);
`endif
    cmp_en = 1;
    reset = 0;
    scan_en = 1;
    wait_idle(40000);

    plot_px(10, 20, 3'b101);
    lookup(10, 20);
    chk("plot_readback", 16'(color_obs), 16'h5);

    plot_px(0, 0, 3'b110);
    plot_px(159, 119, 3'b110);
    lookup(0, 0);
    chk("corner_fill", 16'(color_obs), 16'h6);

    clear = 1; step(); clear = 0;
    bc = 0;
    while (busy && bc < 20000) begin
      x = 8'd5; y = 8'd5; color_draw = 3'b101; plot = (bc == 2000);
      bc++;
      step();
    end
    plot = 0;
    chk("clear_busy_cycles", 16'(bc), 16'd19200);
    lookup(0, 0);     chk("clr_0_0", 16'(color_obs), 16'h0);
    lookup(159, 119); chk("clr_159_119", 16'(color_obs), 16'h0);
    lookup(5, 5);     chk("clr_5_5", 16'(color_obs), 16'h0);

    bc = 0;
    while (fs_q.size() < 2 && bc < 40000) begin step(); bc++; end
    if (fs_q.size() < 2) chk("frame_start_seen", 16'(fs_q.size()), 16'd2);
    else chk("frame_period", 16'(fs_q[1] - fs_q[0]), 16'd19200);

    plot_px(160, 5, 3'b010);
    lookup(0, 6);   chk("oob_plot_no_alias", 16'(color_obs), 16'h0);
    lookup(200, 0); chk("oob_lookup", 16'(color_obs), 16'h7);
    lookup(0, 120); chk("oob_lookup_y", 16'(color_obs), 16'h7);

    plot_px(7, 7, 3'b011);
    chk("write_first", 16'(color_obs), 16'h3);

    random_traffic(3000);

    clear = 1; step(); clear = 0;
    repeat (100) step();
    reset = 1; #1;
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_color_obs", 16'(color_obs), 16'd0);
    chk("midrst_scan_x", 16'(scan_x), 16'd0);
    chk("midrst_scan_y", 16'(scan_y), 16'd0);
    chk("midrst_scan_color", 16'(scan_color), 16'd0);
    chk("midrst_scan_valid", 16'(scan_valid), 16'd0);
    chk("midrst_frame_start", 16'(frame_start), 16'd0);
    @(posedge clk); #1;
    reset = 0;
`ifdef PIXEL_FRAME_STORE_CLEAR_ON_RESET_EN
    bc = 0;
    while (busy && bc < 20000) begin bc++; step(); end
    chk("auto_clear_cycles", 16'(bc), 16'd19200);
`else
    chk("midrst_run_busy", 16'(busy), 16'd0);
`endif
    random_traffic(2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_frame_store.md
Name: pixel_frame_store

Overview:
- Target end of the plot interface driven by the game processor.
- Accepts per-pixel writes (x, y, color_draw, plot) into a WIDTH x HEIGHT x 3-bit frame memory.
- Answers colour lookups back to the processor on color_obs.
- Raster-scans the memory to drive the display path, and provides a full-frame clear sequenced by a small FSM.

Parameters:
- WIDTH, 160, pixels per row; valid x is 0..WIDTH-1.
- HEIGHT, 120, rows per frame; valid y is 0..HEIGHT-1.
- BG_COLOR, 3'b000, colour written by a clear sweep.
- OOB_COLOR, 3'b111, colour returned for out-of-range lookups; the processor treats it as a wall.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- x  in  8  write/lookup column from the processor.
- y  in  8  write/lookup row from the processor.
- color_draw  in  3  pixel colour to write.
- plot  in  1  write strobe; one pixel per cycle while high.
- color_obs  out  3  registered colour at the (x,y) sampled on the previous edge.
- clear  in  1  request a full-frame clear; single-cycle pulse or level.
- busy  out  1  high while a clear sweep is in progress.
- scan_en  in  1  advance the raster scan by one pixel per cycle while high.
- scan_x  out  8  column of the pixel on scan_color.
- scan_y  out  8  row of the pixel on scan_color.
- scan_color  out  3  memory colour at (scan_x, scan_y).
- scan_valid  out  1  scan_x, scan_y and scan_color are valid this cycle.
- frame_start  out  1  one-cycle pulse aligned with scan pixel (0,0).

Behaviour:
- Reset values: color_obs=0, busy=0, scan_x=0, scan_y=0, scan_color=0, scan_valid=0, frame_start=0; FSM=RUN.
- Memory contents are not reset.
- Memory organisation:
  - WIDTH*HEIGHT words of 3 bits; address = y*WIDTH + x, using a 15-bit address.
  - One synchronous write port and two synchronous read ports (lookup, scan).
- FSM states:
  - RUN:
    - plot=1 with x<WIDTH and y<HEIGHT writes color_draw on that edge.
    - Out-of-range plots are silently dropped.
    - clear=1 goes to CLEAR on the next edge; the sweep address starts at 0.
  - CLEAR:
    - Writes BG_COLOR to one address per cycle, 0..WIDTH*HEIGHT-1, with busy=1.
    - Processor plots are ignored and clear is ignored.
    - After the final address is written, returns to RUN and busy drops on the following edge.
    - A full sweep takes exactly WIDTH*HEIGHT cycles (19200 at defaults).
- Lookup (1-cycle latency):
  - color_obs at edge n+1 is the memory word at the (x,y) sampled at edge n.
  - If x>=WIDTH or y>=HEIGHT, color_obs=OOB_COLOR.
  - Same-cycle write to the same address: color_obs returns the newly written colour (write-first).
  - During CLEAR, color_obs returns BG_COLOR for in-range lookups and OOB_COLOR otherwise.
- Scan:
  - Internal counters (sx, sy) advance on each edge with scan_en=1.
  - sx wraps WIDTH-1 -> 0 and increments sy; sy wraps HEIGHT-1 -> 0.
  - Outputs are registered one cycle after the counter value is presented.
    - scan_valid is scan_en delayed one cycle.
    - scan_x and scan_y are the delayed counters.
    - scan_color is the memory read.
  - frame_start=1 exactly when scan_valid=1 and the delayed counters are (0,0).
  - scan_en=0 holds the counters; scan_valid=0 next cycle; scan_x, scan_y and scan_color hold their last values.
  - The scan runs in both RUN and CLEAR and shows current memory, including partially cleared frames.
  - Scan read of an address written the same cycle returns the new data.
- Reset asserted mid-sweep:
  - Immediately forces RUN with busy=0.
  - Memory is left partially cleared, with no further writes.
- Width rules:
  - x and y are compared as unsigned 8-bit values.
  - Values >= WIDTH/HEIGHT are never wrapped into range.

Optional Feature:
- Macro: PIXEL_FRAME_STORE_CLEAR_ON_RESET_EN.
- Defined:
  - Reset places the FSM in CLEAR with busy=1 and sweep address 0.
  - Once reset deasserts, the first full sweep runs automatically before any plot is accepted.
- Undefined:
  - Reset places the FSM in RUN with busy=0.
  - Memory contents are undefined until a clear or writes occur.

Test Plan:
- Plot write then read: plot=1, x=10, y=20, color_draw=3'b101 for one cycle; then x=10, y=20, plot=0 -> color_obs=3'b101 one cycle later.
- Out-of-range: plot=1, x=160, y=5, color_draw=3'b010 -> no memory change (scan of row 5 unchanged); lookup x=200, y=0 -> color_obs=3'b111.
- Clear: fill (0,0) and (159,119) with 3'b110, pulse clear -> busy high for exactly 19200 cycles.
  - Plot to (5,5) during the sweep is ignored.
  - After busy falls, lookups of (0,0), (159,119) and (5,5) all return 3'b000.
- Scan wrap: scan_en=1 continuously from reset -> frame_start pulses every 19200 cycles.
  - The scan_x sequence 158, 159, 0 coincides with scan_y incrementing.
  - scan_y 119 -> 0 coincides with frame_start.
- Write-first collision: plot=1 at (7,7) with 3'b011 while x,y=(7,7) on the same edge -> color_obs=3'b011 next cycle.
- Reset mid-clear: assert reset 100 cycles into a sweep -> busy=0 immediately and all outputs at reset values.
  - With PIXEL_FRAME_STORE_CLEAR_ON_RESET_EN defined, busy is high for 19200 cycles after deassertion.
